tdm_demux8x3: RTL and testbench
===============================

# tdm_demux8x3

Receive-side counterpart of the 8:1 select mux. It recovers eight single-bit channels from a time-division-multiplexed serial line in which the transmitter steps its 3-bit select through slots 0..7 and marks slot 0 with a frame sync. A slot counter and a frame-alignment state machine distribute each bit into a shadow register. Each complete frame is presented as a registered 8-bit word with a one-cycle valid strobe, for use by the downstream parallel logic.

## Interface
- MISS_LIMIT, default 2: number of consecutive missing syncs at slot 0 that drops lock (range 1..7).
- clk  input  1  single system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  slot strobe; din/sync are sampled only when en=1.
- din  input  1  serial TDM data bit for the current slot.
- sync  input  1  frame marker, high together with the slot-0 bit.
- out  output  8  last complete frame; out[k] = channel k (transmitter input ik).
- frame_valid  output  1  one-cycle pulse when out is updated.
- slot  output  3  index of the next slot to be captured ({sel2,sel1,sel0} equivalent).
- locked  output  1  high in LOCKED state.
- sync_err  output  1  one-cycle pulse on a misplaced or missing sync.

## Operation
- Reset (rst=1 at the edge) forces state=HUNT, out=0, shadow=0, slot=0, miss_cnt=0, frame_valid=0, locked=0, sync_err=0. rst overrides all other inputs.
- en=0: state, slot, shadow, miss_cnt and out hold. frame_valid=0 and sync_err=0. sync is ignored.
- HUNT:
  - en&sync: shadow[0]<=din, slot<=1, miss_cnt<=0, go to LOCKED.
  - en&!sync: discard the bit; slot stays 0.
- LOCKED, en=1, slot=s:
  - s≠0, sync=0: shadow[s]<=din, slot<=s+1, with 3-bit wrap from 7 to 0.
  - s≠0, sync=1 (misplaced sync): sync_err pulse. Discard the partial frame by clearing shadow. shadow[0]<=din, slot<=1, miss_cnt<=0. No frame_valid. Stay LOCKED.
  - s=0, sync=1: shadow[0]<=din, slot<=1, miss_cnt<=0.
  - s=0, sync=0 (missing sync): sync_err pulse, miss_cnt<=miss_cnt+1.
    - If miss_cnt+1 = MISS_LIMIT: go to HUNT. The bit is discarded, slot stays 0, miss_cnt<=0.
    - Otherwise (flywheel): shadow[0]<=din, slot<=1.
  - s=7 (no sync): out<={din, shadow[6:0]}, frame_valid<=1, slot<=0.
- locked is the registered state bit. It is high from the edge that leaves HUNT.
- out changes only on a frame_valid edge or on reset. It holds between frames and across loss of lock.

## Timing
- Frame latency: the slot-7 bit sampled at edge N appears on out after edge N, with frame_valid high for exactly the cycle after edge N.
- Minimum frame period is 8 en cycles. Back-to-back frames give one frame_valid every 8 en cycles with no gap.
- sync_err is asserted in the cycle after the offending sample edge.
- slot and locked are registered with no combinational path from inputs.
- Reset mid-frame discards the partial frame. The next frame needs a fresh sync.

## Test plan
- Reset then idle: after rst, out=8'h00, slot=0, locked=0. With en=1, sync=0 for 20 cycles, frame_valid never pulses.
- Aligned frame: sync on slot 0, en=1 continuously, bits i0..i7 = 1,0,1,1,0,0,1,0 -> out=8'h4D, one frame_valid pulse, locked=1, slot back to 0.
- Gated strobe: same frame with en=0 inserted between every slot -> identical out=8'h4D. frame_valid occurs one cycle after the 8th en-high sample.
- Misplaced sync: sync asserted at slot 5 -> sync_err pulse, no frame_valid, slot=1 next. The following 7 bits complete a frame, with the sync-marked bit as channel 0.
- Missing sync with MISS_LIMIT=2: one frame without sync -> sync_err, frame still delivered, locked=1. Second consecutive missing sync -> sync_err, locked=0, slot=0, out holds the previous value.
- Reset mid-frame: rst at slot 4 -> slot=0, locked=0, out=0. The remainder of the frame is ignored until the next sync.

Source files
------------

// File: rtl/tdm_demux8x3.sv
// TDM receiver: recovers eight single-bit channels from a serial line with a slot-0 frame sync
// and presents each complete frame as a registered byte with a one-cycle valid strobe.
module tdm_demux8x3 #(
  parameter int unsigned MISS_LIMIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       din,
  input  logic       sync,
  output logic [7:0] out,
  output logic       frame_valid,
  output logic [2:0] slot,
  output logic       locked,
  output logic       sync_err
);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e     state_q, state_d;
  logic [2:0] slot_q, slot_d;
  logic [7:0] shadow_q, shadow_d;
  logic [2:0] miss_q, miss_d;
  logic [7:0] out_q, out_d;
  logic       fv_q, fv_d;
  logic       err_q, err_d;
  logic [3:0] miss_inc;

  assign miss_inc = {1'b0, miss_q} + 4'd1;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    miss_d   = miss_q;
    out_d    = out_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;
    if (en) begin
      unique case (state_q)
        StHunt: begin
          if (sync) begin
            shadow_d[0] = din;
            slot_d      = 3'd1;
            miss_d      = '0;
            state_d     = StLocked;
          end
        end
        StLocked: begin
          if (slot_q != 3'd0) begin
            if (sync) begin
              // Misplaced sync: realign on this bit and drop the partial frame.
              err_d    = 1'b1;
              shadow_d = {7'd0, din};
              slot_d   = 3'd1;
              miss_d   = '0;
            end else begin
              shadow_d[slot_q] = din;
              slot_d           = slot_q + 3'd1;
              if (slot_q == 3'd7) begin
                out_d = {din, shadow_q[6:0]};
                fv_d  = 1'b1;
              end
            end
          end else if (sync) begin
            shadow_d[0] = din;
            slot_d      = 3'd1;
            miss_d      = '0;
          end else begin
            err_d = 1'b1;
            if (miss_inc == 4'(MISS_LIMIT)) begin
              state_d = StHunt;
              slot_d  = 3'd0;
              miss_d  = '0;
            end else begin
              // Flywheel through a missing sync while still within the miss budget.
              miss_d      = miss_inc[2:0];
              shadow_d[0] = din;
              slot_d      = 3'd1;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StHunt;
      slot_q   <= '0;
      shadow_q <= '0;
      miss_q   <= '0;
      out_q    <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      miss_q   <= miss_d;
      out_q    <= out_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
    end
  end

  assign out         = out_q;
  assign frame_valid = fv_q;
  assign slot        = slot_q;
  assign locked      = (state_q == StLocked);
  assign sync_err    = err_q;

endmodule

// File: tb/tb_tdm_demux8x3.sv
// Scoreboard bench for tdm_demux8x3: expected frames are queued as stimulus is issued and
// checked by a monitor whenever frame_valid pulses.
module tb_tdm_demux8x3;

  logic       clk = 1'b0;
  logic       rst, en, din, sync;
  logic [7:0] out;
  logic       frame_valid, locked, sync_err;
  logic [2:0] slot;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  tdm_demux8x3 #(.MISS_LIMIT(2)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .sync(sync), .out(out),
    .frame_valid(frame_valid), .slot(slot), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every frame_valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame: got %h expected no frame", out);
      end else begin
        chk("frame_out", out, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic d, input logic s);
    en = 1'b1; din = d; sync = s;
    tick();
    sync = 1'b0;
  endtask

  task automatic idle();
    en = 1'b0; sync = 1'b0;
    tick();
  endtask

  // Bits are given as channel 0 first; sync marks the first bit only.
  task automatic send_frame(input logic [7:0] ch, input logic with_sync, input logic gated);
    for (int i = 0; i < 8; i++) begin
      send(ch[i], (i == 0) && with_sync);
      if (gated && i < 7) idle();
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; din = 1'b0; sync = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_out", out, 8'h00);
    chk("reset_slot", {5'd0, slot}, 8'd0);
    chk("reset_locked", {7'd0, locked}, 8'd0);

    // Idle line with no sync: never locks, never frames.
    for (int i = 0; i < 20; i++) send(1'b1, 1'b0);
    chk("idle_locked", {7'd0, locked}, 8'd0);
    chk("idle_slot", {5'd0, slot}, 8'd0);

    // Aligned frame 1,0,1,1,0,0,1,0 -> 8'h4D.
    exp_q.push_back(8'h4D);
    send(1'b1, 1'b1);
    chk("lock_slot", {5'd0, slot}, 8'd1);
    chk("lock_locked", {7'd0, locked}, 8'd1);
    for (int i = 1; i < 8; i++) send(8'h4D >> i, 1'b0);
    chk("aligned_fv", {7'd0, frame_valid}, 8'd1);
    chk("aligned_slot", {5'd0, slot}, 8'd0);
    chk("aligned_locked", {7'd0, locked}, 8'd1);
    idle();
    chk("aligned_fv_off", {7'd0, frame_valid}, 8'd0);

    // Gated strobe: same frame with en=0 between slots.
    exp_q.push_back(8'h4D);
    send_frame(8'h4D, 1'b1, 1'b1);
    chk("gated_fv", {7'd0, frame_valid}, 8'd1);
    chk("gated_out", out, 8'h4D);
    idle();
    chk("gated_fv_off", {7'd0, frame_valid}, 8'd0);
    chk("gated_hold", out, 8'h4D);

    // Misplaced sync at slot 5; sync-marked bit becomes channel 0 of frame 8'h83.
    send(1'b0, 1'b1);
    for (int i = 1; i < 5; i++) send(1'b1, 1'b0);
    chk("pre_mis_slot", {5'd0, slot}, 8'd5);
    send(1'b1, 1'b1);
    chk("mis_err", {7'd0, sync_err}, 8'd1);
    chk("mis_slot", {5'd0, slot}, 8'd1);
    chk("mis_fv", {7'd0, frame_valid}, 8'd0);
    chk("mis_locked", {7'd0, locked}, 8'd1);
    exp_q.push_back(8'h83);
    for (int i = 1; i < 8; i++) send(8'h83 >> i, 1'b0);
    chk("mis_frame_out", out, 8'h83);

    // First missing sync: flywheel, frame 8'h96 still delivered.
    exp_q.push_back(8'h96);
    send(1'b0, 1'b0);
    chk("miss1_err", {7'd0, sync_err}, 8'd1);
    chk("miss1_locked", {7'd0, locked}, 8'd1);
    chk("miss1_slot", {5'd0, slot}, 8'd1);
    for (int i = 1; i < 8; i++) send(8'h96 >> i, 1'b0);
    chk("miss1_out", out, 8'h96);
    // Second consecutive missing sync drops lock.
    send(1'b1, 1'b0);
    chk("miss2_err", {7'd0, sync_err}, 8'd1);
    chk("miss2_locked", {7'd0, locked}, 8'd0);
    chk("miss2_slot", {5'd0, slot}, 8'd0);
    chk("miss2_out_hold", out, 8'h96);
    send(1'b1, 1'b0);
    chk("hunt_err", {7'd0, sync_err}, 8'd0);
    chk("hunt_slot", {5'd0, slot}, 8'd0);

    // Reset mid-frame at slot 4.
    send_frame(8'hFF, 1'b1, 1'b0);
    exp_q.delete();
    exp_q.push_back(8'hFF);
    idle();
    exp_q.delete();
    send(1'b1, 1'b1);
    for (int i = 1; i < 4; i++) send(1'b1, 1'b0);
    chk("pre_rst_slot", {5'd0, slot}, 8'd4);
    rst = 1'b1;
    send(1'b1, 1'b0);
    rst = 1'b0;
    chk("rst_slot", {5'd0, slot}, 8'd0);
    chk("rst_locked", {7'd0, locked}, 8'd0);
    chk("rst_out", out, 8'h00);
    for (int i = 4; i < 8; i++) send(1'b1, 1'b0);
    chk("after_rst_locked", {7'd0, locked}, 8'd0);
    chk("after_rst_slot", {5'd0, slot}, 8'd0);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("relock_out", out, 8'hA5);
    idle();
    idle();

    chk("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
